// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector: y/state registered, valid from the edge sampling the last bit; x consumed on every en edge (no backpressure).
// Define MOORE_DET_MATCH_CNT_EN to build the saturating match counter; otherwise match_count is tied to 0.
module moore_seq_detector #(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           clr,
  input  logic                           x,
  output logic                           y,
  output logic [$clog2(SEQ_LEN+1)-1:0]   state,
  output logic [CNT_W-1:0]               match_count
);

  localparam int SW = $clog2(SEQ_LEN + 1);
  typedef logic [SW-1:0] state_t;
  localparam state_t S_FULL = state_t'(SEQ_LEN);

  if (SEQ_LEN < 2 || SEQ_LEN > 16) begin : g_bad_len
    $error("moore_seq_detector: SEQ_LEN must be within 2..16");
  end

  state_t             s_q, s_d, s_calc;
  logic [SEQ_LEN-2:0] hist_q, hist_d;
  logic [SEQ_LEN-1:0] stream;
  logic               full_hit;

  // Longest pattern prefix ending at the newest bit, never longer than kmax;
  // kmax keeps stale history from creating matches the state cannot justify.
  function automatic state_t next_state(input logic [SEQ_LEN-1:0] str, input state_t s);
    int     kmax;
    state_t best;
    logic   hit;
    if (!OVERLAP && s == S_FULL) kmax = 1;
    else                         kmax = (int'(s) + 1 > SEQ_LEN) ? SEQ_LEN : int'(s) + 1;
    best = '0;
    for (int k = 1; k <= SEQ_LEN; k++) begin
      hit = (k <= kmax);
      for (int j = 0; j < k; j++) begin
        if (str[j] != PATTERN[SEQ_LEN-k+j]) hit = 1'b0;
      end
      if (hit) best = state_t'(k);
    end
    return best;
  endfunction

  always_comb begin
    stream   = {hist_q, x};
    s_calc   = next_state(stream, s_q);
    s_d      = s_q;
    hist_d   = hist_q;
    full_hit = 1'b0;
    if (clr) begin
      s_d    = '0;
      hist_d = '0;
    end else if (en) begin
      s_d      = s_calc;
      hist_d   = stream[SEQ_LEN-2:0];
      full_hit = (s_calc == S_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q    <= '0;
      hist_q <= '0;
    end else begin
      s_q    <= s_d;
      hist_q <= hist_d;
    end
  end

  assign y     = (s_q == S_FULL);
  assign state = s_q;

`ifdef MOORE_DET_MATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                              cnt_d = '0;
    else if (full_hit && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign match_count = cnt_q;
`else
  logic unused_hit;
  assign unused_hit  = full_hit;
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench for moore_seq_detector: four parameterisations share one stimulus stream.
module tb_moore_seq_detector;

`ifdef MOORE_DET_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, en, clr, x;
  logic       ya, yb, yc, yd;
  logic [2:0] sa, sb, sc, sd;
  logic [7:0] ca, cb, cd;
  logic [1:0] cc;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  moore_seq_detector u_a (.clk(clk), .rst(rst), .en(en), .clr(clr), .x(x),
                          .y(ya), .state(sa), .match_count(ca));
  moore_seq_detector #(.OVERLAP(1'b0)) u_b (.clk(clk), .rst(rst), .en(en), .clr(clr), .x(x),
                          .y(yb), .state(sb), .match_count(cb));
  moore_seq_detector #(.SEQ_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) u_c (
                          .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x),
                          .y(yc), .state(sc), .match_count(cc));
  moore_seq_detector #(.SEQ_LEN(6), .PATTERN(6'b010010), .OVERLAP(1'b1)) u_d (
                          .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x),
                          .y(yd), .state(sd), .match_count(cd));

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ecnt(input int n);
    return CNT_ON ? n : 0;
  endfunction

  task automatic step(input logic xi, input logic ei);
    x  = xi;
    en = ei;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step(1'b1, 1'b1);
    clr = 1'b0;
  endtask

  int ov_x [7] = '{1, 0, 1, 1, 0, 1, 1};
  int ov_sa[7] = '{1, 2, 3, 4, 2, 3, 4};
  int ov_sb[7] = '{1, 2, 3, 4, 0, 1, 1};
  int d_x  [9] = '{0, 1, 0, 0, 1, 0, 0, 1, 0};
  int d_s  [9] = '{1, 2, 3, 4, 5, 6, 4, 5, 6};

  initial begin
    rst = 1'b0; en = 1'b1; clr = 1'b0; x = 1'b0;

    // Held in reset with x toggling.
    for (int i = 0; i < 3; i++) begin
      step(1'(i % 2 == 0), 1'b1);
      check("rst_y", int'(ya), 0);
      check("rst_state", int'(sa), 0);
      check("rst_cnt", int'(ca), 0);
      check("rst_cnt_c", int'(cc), 0);
    end
    rst = 1'b1;

    // Mid-pattern asynchronous reset.
    step(1'b1, 1'b1); check("pre_s1", int'(sa), 1);
    step(1'b0, 1'b1); check("pre_s2", int'(sa), 2);
    step(1'b1, 1'b1); check("pre_s3", int'(sa), 3);
    rst = 1'b0;
    #2;
    check("async_rst_state", int'(sa), 0);
    check("async_rst_y", int'(ya), 0);
    #1 rst = 1'b1;
    step(1'b1, 1'b1); check("post_rst_s", int'(sa), 1);

    // Overlapping vs non-overlapping on 1011011.
    pulse_clr();
    check("clr_state", int'(sa), 0);
    for (int i = 0; i < 7; i++) begin
      step(1'(ov_x[i]), 1'b1);
      check($sformatf("ov_sa_%0d", i + 1), int'(sa), ov_sa[i]);
      check($sformatf("ov_ya_%0d", i + 1), int'(ya), int'(ov_sa[i] == 4));
      check($sformatf("ov_sb_%0d", i + 1), int'(sb), ov_sb[i]);
      check($sformatf("ov_yb_%0d", i + 1), int'(yb), int'(ov_sb[i] == 4));
    end
    check("ov_cnt_a", int'(ca), ecnt(2));
    check("ov_cnt_b", int'(cb), ecnt(1));

    // Enable gating, including a held full match.
    pulse_clr();
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
    check("en_s3", int'(sa), 3);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      check($sformatf("en_gap_s_%0d", i), int'(sa), 3);
      check($sformatf("en_gap_y_%0d", i), int'(ya), 0);
    end
    step(1'b1, 1'b1);
    check("en_final_y", int'(ya), 1);
    check("en_final_s", int'(sa), 4);
    step(1'b0, 1'b0);
    check("en_hold_y", int'(ya), 1);
    check("en_hold_s", int'(sa), 4);
    check("en_hold_cnt", int'(ca), ecnt(1));

    // Saturating counter on the 1111 detector.
    pulse_clr();
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1);
      check($sformatf("sat_s_%0d", i), int'(sc), (i < 4) ? i : 4);
      check($sformatf("sat_y_%0d", i), int'(yc), int'(i >= 4));
      if (i == 5) check("sat_cnt_5", int'(cc), ecnt(2));
    end
    check("sat_cnt_end", int'(cc), ecnt(3));
    pulse_clr();
    check("sat_clr_cnt", int'(cc), 0);
    check("sat_clr_s", int'(sc), 0);
    check("sat_clr_y", int'(yc), 0);

    // Six-bit pattern 010010 with overlap.
    pulse_clr();
    for (int i = 0; i < 9; i++) begin
      step(1'(d_x[i]), 1'b1);
      check($sformatf("p6_s_%0d", i + 1), int'(sd), d_s[i]);
      check($sformatf("p6_y_%0d", i + 1), int'(yd), int'(d_s[i] == 6));
    end
    check("p6_cnt", int'(cd), ecnt(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/moore_seq_detector.md
Name: moore_seq_detector

Overview:
- Parametrised Moore-type serial pattern detector; generalises the fixed single-pattern D-flip-flop Moore machine.
- Samples one serial bit `x` per enabled clock and raises `y` for one cycle whenever the last SEQ_LEN bits equal PATTERN.
- Overlapping or non-overlapping detection is selectable by parameter.
- Used as the lab-standard framing/sync detector in front of serial-receive datapaths.

Parameters:
- SEQ_LEN, 4: pattern length in bits; legal 2..16.
- PATTERN, 4'b1011: SEQ_LEN-bit pattern. PATTERN[SEQ_LEN-1] is the first bit received.
- OVERLAP, 1: 1 = overlapping detection; 0 = restart matching after each hit.
- CNT_W, 8: width of the match counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (rst = 0 resets).
- en  input  1  sample enable; x is consumed only on edges where en = 1.
- clr  input  1  synchronous clear of state, history and counter; priority over en.
- x  input  1  serial data bit.
- y  output  1  Moore detect flag.
- state  output  $clog2(SEQ_LEN+1)  current matched-prefix length, for debug.
- match_count  output  CNT_W  number of detections, saturating.

Behaviour:
- State encoding: s in 0..SEQ_LEN = length of the longest PATTERN prefix matching the tail of the received stream.
- Output decode: y = (s == SEQ_LEN), taken from registers only; no combinational path x -> y.
- History: register hist holds the last SEQ_LEN-1 received bits and shifts in x on each enabled edge.
- Next state, with stream = {hist, x}: s_next = largest k <= kmax such that the last k bits of stream equal PATTERN[SEQ_LEN-1 -: k]; s_next = 0 if no k >= 1 matches.
- kmax when OVERLAP = 1: min(s+1, SEQ_LEN).
- kmax when OVERLAP = 0: min(s+1, SEQ_LEN) if s < SEQ_LEN; 1 if s == SEQ_LEN (matching restarts from the new bit alone).
- Latency: last pattern bit sampled at edge N -> y = 1 from edge N until edge N+1. y stays high across consecutive edges only if each enabled edge again completes a match.
- en = 0: s, hist and match_count hold; y holds its value (a held full match keeps y = 1).
- clr = 1 at an edge: s = 0, hist = 0, match_count = 0, regardless of en and x.
- Reset (rst = 0, asynchronous, any time including mid-pattern): s = 0, hist = 0, y = 0, state = 0, match_count = 0. All outputs are 0 while rst = 0.
- After reset release: the first enabled edge starts matching from s = 0; a partial match received before reset is discarded.
- Counter: increments on every edge where s_next == SEQ_LEN and en = 1. It saturates at 2^CNT_W-1 (no wrap).
- Legality: SEQ_LEN outside 2..16 is illegal and must be caught by an elaboration-time check.

Optional Feature:
- Macro: MOORE_DET_MATCH_CNT_EN.
- Defined: match_count and its saturating counter are implemented as above.
- Undefined: no counter flops; match_count is tied to 0. y and state are unaffected.

Test Plan:
- Reset: rst = 0 for 3 cycles with x toggling -> y = 0, state = 0, match_count = 0. Assert rst mid-pattern (after 1,0,1) -> state returns to 0 immediately, without waiting for a clock edge.
- OVERLAP = 1, PATTERN = 1011, x = 1,0,1,1,0,1,1 on consecutive edges -> y = 1 after the 4th and 7th edges only; match_count = 2.
- OVERLAP = 0, same stream -> y = 1 after the 4th edge only; state after the 7th edge = 1; match_count = 1.
- en gating: x = 1,0,1 with en = 1, then 3 edges with en = 0 and x = 0, then x = 1 with en = 1 -> no reaction during the gap; y = 1 after the final edge.
- Saturation (CNT_W = 2, OVERLAP = 1, PATTERN = 1111): x = 1 for 10 edges -> y high from edge 4 onward; match_count stops at 3. clr pulse -> match_count = 0, state = 0.
- SEQ_LEN = 6, PATTERN = 6'b010010, OVERLAP = 1: x = 0,1,0,0,1,0,0,1,0 -> y = 1 after edges 6 and 9.
